lsu_mem_port: RTL and testbench
===============================

LSU_MEM_PORT -- requirements
Module: lsu_mem_port

Interface
REQ-001 SHALL have no parameters; the data memory is word-addressed through byte address bits [7:2] on the memory side.
REQ-002 SHALL have port clk, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port req_valid, input, 1 bit: CPU load/store request.
REQ-005 SHALL have port req_ready, output, 1 bit: high only in IDLE; a request is accepted on an edge where req_valid and req_ready are both high.
REQ-006 SHALL have port req_we, input, 1 bit: 1 = store, 0 = load.
REQ-007 SHALL have port req_funct3, input, 3 bits: RISC-V width code. Loads: 0 lb, 1 lh, 2 lw, 4 lbu, 5 lhu. Stores: 0 sb, 1 sh, 2 sw.
REQ-008 SHALL have port req_addr, input, 32 bits: byte address.
REQ-009 SHALL have port req_wdata, input, 32 bits: store data, right-aligned.
REQ-010 SHALL have port resp_valid, output, 1 bit: one-cycle completion pulse; no backpressure.
REQ-011 SHALL have port resp_rdata, output, 32 bits: formatted load data; 0 for stores and errors.
REQ-012 SHALL have port resp_err, output, 1 bit: misaligned access or illegal funct3, qualified by resp_valid.
REQ-013 SHALL have port mem_we, output, 1 bit: memory write enable.
REQ-014 SHALL have port mem_addr, output, 32 bits: memory byte address.
REQ-015 SHALL have port mem_din, output, 32 bits: memory write data.
REQ-016 SHALL have port mem_dout, input, 32 bits: memory read data.

Function
REQ-017 Memory contract: SHALL assume the memory samples mem_addr and mem_din at every edge. mem_dout is valid in the cycle after the address is presented. mem_we high at edge E writes the mem_din and mem_addr sampled at edge E-1.
REQ-018 SHALL implement the states IDLE, ISSUE, READ, MERGE, COMMIT and RESP, and SHALL hold no other request state.
REQ-019 On accept SHALL latch addr, funct3, we and wdata; mem_addr SHALL equal the latched addr in every state.
REQ-020 Error check at accept SHALL flag misaligned access (word with addr[1:0]!=0; half with addr[0]!=0) and illegal funct3 (load 3/6/7, store >=3).
REQ-021 On an error: IDLE->RESP; resp_err=1; resp_rdata=0; mem_we never asserted.
REQ-022 Load transitions SHALL be IDLE->ISSUE->READ->RESP; mem_dout is captured at the end of READ; resp_valid is high 3 cycles after the accept edge.
REQ-023 Load formatting SHALL select the byte by addr[1:0] and the half by addr[1]; lb/lh sign-extend; lbu/lhu zero-extend; lw passes the word through.
REQ-024 sw transitions SHALL be IDLE->ISSUE->COMMIT->RESP; mem_din=wdata in ISSUE and COMMIT; mem_we=1 only in COMMIT.
REQ-025 sb/sh transitions SHALL be IDLE->ISSUE->READ->MERGE->COMMIT->RESP (read-modify-write).
REQ-026 In MERGE, mem_din SHALL be the old word with the target byte or half replaced by wdata[7:0] or wdata[15:0] at its lane; mem_din SHALL be held through COMMIT.
REQ-027 mem_we SHALL be decoded from state (COMMIT only) and never asserted in any other state.
REQ-028 RESP SHALL last exactly one cycle and then go to IDLE; req_ready SHALL be 0 in RESP, so a new request is accepted no earlier than the following cycle.
REQ-029 mem_din outside ISSUE/MERGE/COMMIT SHALL hold its last value; it is don't-care for the memory.

Reset
REQ-030 rst high at an edge SHALL force IDLE: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_we=0, mem_addr=0, mem_din=0, latched request cleared.
REQ-031 Reset mid-operation SHALL drop the request with no resp_valid.
REQ-032 A write whose mem_we is already high in COMMIT at the reset edge completes in memory at that edge.
REQ-033 No write SHALL occur after the reset edge.
REQ-034 rst SHALL take priority over req_valid on the same edge.

Verification
REQ-035 Word store/load: sw addr 0x10 data 0xDEADBEEF, then lw 0x10 -> resp_rdata=0xDEADBEEF, resp_err=0; load resp_valid exactly 3 cycles after accept.
REQ-036 Sign/zero extension: word 0x80FF7F01 at 0x20.
- lb 0x23 -> 0xFFFFFF80
- lbu 0x23 -> 0x00000080
- lh 0x22 -> 0xFFFF80FF
- lhu 0x20 -> 0x00007F01
REQ-037 Sub-word RMW: word 0x11223344 at 0x30.
- sb 0x31 data 0xAA -> memory word 0x1122AA44.
- sh 0x32 data 0xBEEF -> memory word 0xBEEFAA44.
- mem_we high for exactly one cycle per store.
REQ-038 Errors: each of the following -> resp_valid 1 cycle after accept, resp_err=1, resp_rdata=0, no mem_we:
- lw 0x41
- sh 0x43
- load funct3=3
REQ-039 Reset mid-RMW: assert rst during the MERGE cycle of sb -> memory word unchanged, no resp_valid, req_ready=1 on the next cycle.
REQ-040 Back-to-back: req_valid held high with 3 queued loads -> exactly one accept per transaction; req_ready low from ISSUE through RESP.

Source files
------------

// File: rtl/lsu_mem_port.sv
// Load/store unit port to a word-wide, one-cycle-latency data memory.
// Sub-word stores are handled as read-modify-write. Misaligned accesses and
// illegal width codes are answered with an error response and never touch memory.
module lsu_mem_port (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_din,
   input  logic [31:0] mem_dout
);

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      READ,
      MERGE,
      COMMIT,
      RESP
   } state_t;

   state_t      state, next_state;
   logic [31:0] addr_q;
   logic [2:0]  funct3_q;
   logic        we_q;
   logic [31:0] word_q;
   logic [31:0] din_q;

   logic        accept;
   logic        req_err;
   logic        lat_err;
   logic [31:0] load_data;
   logic [31:0] merged;

   // Misaligned access or width code not defined for the access direction.
   function automatic logic access_error(input logic we, input logic [2:0] f3,
                                         input logic [1:0] a);
      logic illegal;
      logic misaligned;
      if (we)
         illegal = (f3 > 3'd2);
      else
         illegal = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
      misaligned = ((f3[1:0] == 2'd2) && (a != 2'd0)) ||
                   ((f3[1:0] == 2'd1) && a[0]);
      return illegal || misaligned;
   endfunction

   assign accept  = req_valid && (state == IDLE);
   assign req_err = access_error(req_we, req_funct3, req_addr[1:0]);
   // The error is re-derived from the latched request rather than kept in a flag.
   assign lat_err = access_error(we_q, funct3_q, addr_q[1:0]);

   // State register and latched request; the store lane merge is taken from mem_dout at the end of READ.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         addr_q   <= '0;
         funct3_q <= '0;
         we_q     <= 1'b0;
         word_q   <= '0;
         din_q    <= '0;
      end else begin
         state <= next_state;
         if (accept) begin
            addr_q   <= req_addr;
            funct3_q <= req_funct3;
            we_q     <= req_we;
            if (!req_err)
               din_q <= req_wdata;
         end
         if (state == READ) begin
            word_q <= mem_dout;
            if (we_q)
               din_q <= merged;
         end
      end
   end

   // Next-state sequencing: loads ISSUE/READ, sw ISSUE/COMMIT, sb/sh ISSUE/READ/MERGE/COMMIT.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (req_valid)
               next_state = req_err ? RESP : ISSUE;
         end
         ISSUE: begin
            if (we_q && (funct3_q[1:0] == 2'd2))
               next_state = COMMIT;
            else
               next_state = READ;
         end
         READ:    next_state = we_q ? MERGE : RESP;
         MERGE:   next_state = COMMIT;
         COMMIT:  next_state = RESP;
         RESP:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Sub-word store merge: replace the addressed byte or half of the old word.
   always_comb begin
      logic [31:0] mask;
      logic [31:0] lane_data;
      mask      = '0;
      lane_data = '0;
      if (funct3_q[1:0] == 2'd0) begin
         mask      = 32'h0000_00FF << {addr_q[1:0], 3'b000};
         lane_data = {4{din_q[7:0]}};
      end else begin
         mask      = addr_q[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
         lane_data = {2{din_q[15:0]}};
      end
      merged = (mem_dout & ~mask) | (lane_data & mask);
   end

   // Load formatting: lane select by address, then sign or zero extension.
   always_comb begin
      logic [31:0] shifted;
      logic [15:0] half;
      shifted   = word_q >> {addr_q[1:0], 3'b000};
      half      = addr_q[1] ? word_q[31:16] : word_q[15:0];
      load_data = '0;
      case (funct3_q)
         3'd0:    load_data = {{24{shifted[7]}}, shifted[7:0]};
         3'd1:    load_data = {{16{half[15]}}, half};
         3'd2:    load_data = word_q;
         3'd4:    load_data = {24'd0, shifted[7:0]};
         3'd5:    load_data = {16'd0, half};
         default: load_data = '0;
      endcase
   end

   // Outputs decoded from state.
   always_comb begin
      req_ready  = (state == IDLE);
      resp_valid = (state == RESP);
      resp_err   = (state == RESP) && lat_err;
      resp_rdata = '0;
      if ((state == RESP) && !we_q && !lat_err)
         resp_rdata = load_data;
      mem_we   = (state == COMMIT);
      mem_addr = addr_q;
      mem_din  = din_q;
   end

endmodule

// File: tb/tb_lsu_mem_port.sv
// Directed testbench for lsu_mem_port with a behavioural one-cycle-latency memory.
module tb_lsu_mem_port;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [2:0]  req_funct3 = 3'd0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_din;
   logic [31:0] mem_dout;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   lsu_mem_port dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_din    (mem_din),
      .mem_dout   (mem_dout)
   );

   // Memory: samples address/data every edge, read data valid next cycle,
   // a write at edge E uses address/data sampled at E-1.
   logic [31:0] mem [0:63];
   logic [31:0] a_s = '0;
   logic [31:0] d_s = '0;
   always @(posedge clk) begin
      if (mem_we) mem[a_s[7:2]] <= d_s;
      a_s <= mem_addr;
      d_s <= mem_din;
   end
   assign mem_dout = mem[a_s[7:2]];

   int we_cnt = 0;
   int acc_cnt = 0;
   always @(posedge clk) begin
      if (mem_we) we_cnt <= we_cnt + 1;
      if (req_valid && req_ready && !rst) acc_cnt <= acc_cnt + 1;
   end

   // Issue one request from IDLE; lat = negedges after accept until resp_valid (-1 on timeout).
   task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d, output int lat, output logic [31:0] rd,
                         output logic er);
      @(negedge clk);
      req_valid  = 1'b1;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = a;
      req_wdata  = d;
      @(posedge clk);
      lat = -1;
      rd  = 'x;
      er  = 1'bx;
      for (int n = 1; n <= 12; n++) begin
         @(negedge clk);
         req_valid = 1'b0;
         if (resp_valid) begin
            lat = n;
            rd  = resp_rdata;
            er  = resp_err;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_funct3 = 3'd2;
      req_addr  = 32'h44;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
      checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b expected 0", resp_valid); end
      checks++; if (resp_rdata !== 32'h0) begin errors++; $display("FAIL reset_resp_rdata: got %h expected 0", resp_rdata); end
      checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL reset_resp_err: got %b expected 0", resp_err); end
      checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %b expected 0", mem_we); end
      checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_priority_mem_addr: got %h expected 0", mem_addr); end
      checks++; if (mem_din !== 32'h0) begin errors++; $display("FAIL reset_mem_din: got %h expected 0", mem_din); end
      req_valid = 1'b0;
      rst       = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_word();
      int lat; logic [31:0] rd; logic er; int w0;
      w0 = we_cnt;
      do_req(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, lat, rd, er);
      checks++; if (lat != 3) begin errors++; $display("FAIL sw_latency: got %0d expected 3", lat); end
      checks++; if (er !== 1'b0) begin errors++; $display("FAIL sw_err: got %b expected 0", er); end
      checks++; if (mem[4] !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_mem: got %h expected deadbeef", mem[4]); end
      checks++; if (we_cnt - w0 != 1) begin errors++; $display("FAIL sw_we_pulses: got %0d expected 1", we_cnt - w0); end
      w0 = we_cnt;
      do_req(1'b0, 3'd2, 32'h10, 32'h0, lat, rd, er);
      checks++; if (lat != 3) begin errors++; $display("FAIL lw_latency: got %0d expected 3", lat); end
      checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_rdata: got %h expected deadbeef", rd); end
      checks++; if (er !== 1'b0) begin errors++; $display("FAIL lw_err: got %b expected 0", er); end
      checks++; if (we_cnt != w0) begin errors++; $display("FAIL lw_no_write: got %0d expected 0", we_cnt - w0); end
      @(negedge clk);
      checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL resp_one_cycle: got %b expected 0", resp_valid); end
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL ready_after_resp: got %b expected 1", req_ready); end
   endtask

   task automatic test_extension();
      int lat; logic [31:0] rd; logic er;
      logic [2:0]  f3s [4];
      logic [31:0] ads [4];
      logic [31:0] exp [4];
      f3s = '{3'd0, 3'd4, 3'd1, 3'd5};
      ads = '{32'h23, 32'h23, 32'h22, 32'h20};
      exp = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h00007F01};
      do_req(1'b1, 3'd2, 32'h20, 32'h80FF7F01, lat, rd, er);
      checks++; if (mem[8] !== 32'h80FF7F01) begin errors++; $display("FAIL ext_preload: got %h expected 80ff7f01", mem[8]); end
      for (int i = 0; i < 4; i++) begin
         do_req(1'b0, f3s[i], ads[i], 32'h0, lat, rd, er);
         checks++; if (lat != 3) begin errors++; $display("FAIL ext_latency[%0d]: got %0d expected 3", i, lat); end
         checks++; if (rd !== exp[i]) begin errors++; $display("FAIL ext_rdata[%0d]: got %h expected %h", i, rd, exp[i]); end
         checks++; if (er !== 1'b0) begin errors++; $display("FAIL ext_err[%0d]: got %b expected 0", i, er); end
      end
   endtask

   task automatic test_rmw();
      int lat; logic [31:0] rd; logic er; int w0;
      do_req(1'b1, 3'd2, 32'h30, 32'h11223344, lat, rd, er);
      w0 = we_cnt;
      do_req(1'b1, 3'd0, 32'h31, 32'h000000AA, lat, rd, er);
      checks++; if (lat != 5) begin errors++; $display("FAIL sb_latency: got %0d expected 5", lat); end
      checks++; if (mem[12] !== 32'h1122AA44) begin errors++; $display("FAIL sb_mem: got %h expected 1122aa44", mem[12]); end
      checks++; if (we_cnt - w0 != 1) begin errors++; $display("FAIL sb_we_pulses: got %0d expected 1", we_cnt - w0); end
      checks++; if (er !== 1'b0 || rd !== 32'h0) begin errors++; $display("FAIL sb_resp: got err %b rdata %h expected 0/0", er, rd); end
      w0 = we_cnt;
      do_req(1'b1, 3'd1, 32'h32, 32'h0000BEEF, lat, rd, er);
      checks++; if (lat != 5) begin errors++; $display("FAIL sh_latency: got %0d expected 5", lat); end
      checks++; if (mem[12] !== 32'hBEEFAA44) begin errors++; $display("FAIL sh_mem: got %h expected beefaa44", mem[12]); end
      checks++; if (we_cnt - w0 != 1) begin errors++; $display("FAIL sh_we_pulses: got %0d expected 1", we_cnt - w0); end
   endtask

   task automatic test_errors();
      int lat; logic [31:0] rd; logic er; int w0;
      logic        wes [4];
      logic [2:0]  f3s [4];
      logic [31:0] ads [4];
      wes = '{1'b0, 1'b1, 1'b0, 1'b1};
      f3s = '{3'd2, 3'd1, 3'd3, 3'd3};
      ads = '{32'h41, 32'h43, 32'h40, 32'h40};
      for (int i = 0; i < 4; i++) begin
         w0 = we_cnt;
         do_req(wes[i], f3s[i], ads[i], 32'h12345678, lat, rd, er);
         checks++; if (lat != 1) begin errors++; $display("FAIL err_latency[%0d]: got %0d expected 1", i, lat); end
         checks++; if (er !== 1'b1) begin errors++; $display("FAIL err_flag[%0d]: got %b expected 1", i, er); end
         checks++; if (rd !== 32'h0) begin errors++; $display("FAIL err_rdata[%0d]: got %h expected 0", i, rd); end
         @(negedge clk);
         checks++; if (we_cnt != w0) begin errors++; $display("FAIL err_no_write[%0d]: got %0d expected 0", i, we_cnt - w0); end
      end
      checks++; if (mem[16] === 32'h12345678) begin errors++; $display("FAIL err_mem_untouched: got %h expected not 12345678", mem[16]); end
   endtask

   task automatic test_reset_mid_rmw();
      int w0; int seen;
      w0 = we_cnt;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd0;
      req_addr = 32'h30; req_wdata = 32'h00000055;
      @(posedge clk);
      @(negedge clk); req_valid = 1'b0;   // ISSUE
      @(negedge clk);                     // READ
      @(negedge clk);                     // MERGE
      checks++; if (mem_din !== 32'hBEEFAA55) begin errors++; $display("FAIL merge_din: got %h expected beefaa55", mem_din); end
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_rmw_ready: got %b expected 1", req_ready); end
      checks++; if (mem[12] !== 32'hBEEFAA44) begin errors++; $display("FAIL rst_rmw_mem: got %h expected beefaa44", mem[12]); end
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         if (resp_valid) seen++;
         @(negedge clk);
      end
      checks++; if (seen != 0) begin errors++; $display("FAIL rst_rmw_no_resp: got %0d expected 0", seen); end
      checks++; if (we_cnt != w0) begin errors++; $display("FAIL rst_rmw_no_write: got %0d expected 0", we_cnt - w0); end
   endtask

   task automatic test_back_to_back();
      logic [2:0]  f3s [3];
      logic [31:0] ads [3];
      logic [31:0] exp [3];
      int a0; int idx; int nresp; int low;
      f3s = '{3'd2, 3'd4, 3'd5};
      ads = '{32'h10, 32'h23, 32'h32};
      exp = '{32'hDEADBEEF, 32'h00000080, 32'h0000BEEF};
      a0 = acc_cnt; nresp = 0; low = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (!req_ready) low++;
         if (resp_valid) begin
            checks++; if (resp_rdata !== exp[nresp]) begin errors++; $display("FAIL b2b_rdata[%0d]: got %h expected %h", nresp, resp_rdata, exp[nresp]); end
            checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_in_resp[%0d]: got %b expected 0", nresp, req_ready); end
            nresp++;
         end
         idx = acc_cnt - a0;
         if (idx < 3) begin
            req_valid = 1'b1; req_we = 1'b0;
            req_funct3 = f3s[idx]; req_addr = ads[idx];
         end else begin
            req_valid = 1'b0;
         end
         if (nresp == 3) break;
      end
      req_valid = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (nresp != 3) begin errors++; $display("FAIL b2b_responses: got %0d expected 3", nresp); end
      checks++; if (acc_cnt - a0 != 3) begin errors++; $display("FAIL b2b_accepts: got %0d expected 3", acc_cnt - a0); end
      checks++; if (low != 9) begin errors++; $display("FAIL b2b_ready_low_cycles: got %0d expected 9", low); end
   endtask

   initial begin
      test_reset();
      test_word();
      test_extension();
      test_rmw();
      test_errors();
      test_reset_mid_rmw();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
